// File: rtl/caesar_display_if.sv
// +--------------------------------------------------------------------------+
// | Module      : caesar_display_if                                          |
// | Description : Bundles the Caesar display front-end data signals.         |
// |               sw        - 5-bit key/letter value into the core           |
// |               Clk_1Hz   - divided square wave out of the core            |
// |               tick      - one-cycle pulse per divider period             |
// |               bcd_hund  - hundreds digit of sw                           |
// |               hex0..3   - active-low 7-seg digits, index 0 = segment a   |
// |               slave  modport: the display core                           |
// |               master modport: whoever drives sw and watches the digits   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface caesar_display_if;
  logic [4:0] sw;
  logic       Clk_1Hz;
  logic       tick;
  logic [1:0] bcd_hund;
  logic [0:6] hex0;
  logic [0:6] hex1;
  logic [0:6] hex2;
  logic [0:6] hex3;

  modport master (
    output sw,
    input  Clk_1Hz, tick, bcd_hund, hex0, hex1, hex2, hex3
  );

  modport slave (
    input  sw,
    output Clk_1Hz, tick, bcd_hund, hex0, hex1, hex2, hex3
  );
endinterface

`default_nettype wire

// File: rtl/caesar_display_core.sv
// +--------------------------------------------------------------------------+
// | Module      : caesar_display_core (with helper caesar_seg7_dec)          |
// | Description : Display front-end of the Caesar-cipher board. Divides      |
// |               Clk_50MHz into a tick / Clk_1Hz, runs a BCD letter counter |
// |               00..LAST_VAL on the tick, converts sw to BCD and drives    |
// |               four active-low 7-segment digits.                           |
// |   Ports     : Clk_50MHz - the only clock                                 |
// |               rst       - asynchronous reset, active-low                 |
// |               bus       - caesar_display_if.slave (sw in, display out)   |
// |   Params    : DIV       - clock cycles per tick period (>= 2)            |
// |               LAST_VAL  - counter terminal value, decimal (<= 39)        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

// Active-low 7-segment decoder; seg[0] = a .. seg[6] = g. Codes 10..15 blank.
module caesar_seg7_dec (
  input  logic [3:0] bcd,
  output logic [0:6] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module caesar_display_core #(
  parameter int DIV      = 50_000_000,
  parameter int LAST_VAL = 25
) (
  input  logic              Clk_50MHz,
  input  logic              rst,
  caesar_display_if.slave   bus
);
  localparam int                 c_cnt_w     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half  = c_cnt_w'(DIV / 2);
  localparam logic [3:0]         c_last_ones = 4'(LAST_VAL % 10);
  localparam logic [1:0]         c_last_tens = 2'(LAST_VAL / 10);

  // Reset asserts asynchronously straight through both flops; release is
  // delayed two clocks so every downstream flop leaves reset on the same edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge Clk_50MHz or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Divider: r_cnt walks 0..DIV-1; tick and Clk_1Hz are registered decodes of it.
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_tick;
  logic               r_clk_1hz;

  always_ff @(posedge Clk_50MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_1hz <= 1'b0;
    end else begin
      r_cnt     <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
      r_tick    <= (r_cnt == c_cnt_last);
      r_clk_1hz <= (r_cnt < c_cnt_half);
    end
  end

  // Plaintext letter counter in BCD, advanced by the tick as a clock enable.
  logic [3:0] r_ones;
  logic [1:0] r_tens;

  always_ff @(posedge Clk_50MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ones <= 4'd0;
      r_tens <= 2'd0;
    end else if (r_tick) begin
      if (r_tens == c_last_tens && r_ones == c_last_ones) begin
        r_ones <= 4'd0;
        r_tens <= 2'd0;
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 2'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  // Switch value to BCD; 5-bit input tops out at 31, so tens fits 2 bits.
  logic [3:0] w_sw_ones;
  logic [1:0] w_sw_tens;

  assign w_sw_ones    = 4'(bus.sw % 5'd10);
  assign w_sw_tens    = 2'(bus.sw / 5'd10);
  assign bus.bcd_hund = 2'({2'b00, bus.sw} / 7'd100);

  assign bus.tick     = r_tick;
  assign bus.Clk_1Hz  = r_clk_1hz;

  caesar_seg7_dec u_hex0 (.bcd(r_ones),             .seg(bus.hex0));
  caesar_seg7_dec u_hex1 (.bcd({2'b00, r_tens}),    .seg(bus.hex1));
  caesar_seg7_dec u_hex2 (.bcd(w_sw_ones),          .seg(bus.hex2));
  caesar_seg7_dec u_hex3 (.bcd({2'b00, w_sw_tens}), .seg(bus.hex3));
endmodule

`default_nettype wire

// File: tb/tb_caesar_display_core.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_caesar_display_core                                     |
// | Description : Self-checking bench for caesar_display_core (DIV = 4).     |
// |               A negedge monitor keeps a decimal letter count and checks  |
// |               the counter digits, tick period and Clk_1Hz duty; tables   |
// |               and random sw values check the switch digits; the 7-seg    |
// |               decoder is also exercised directly for codes 0..15.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_caesar_display_core;
  localparam int DIV  = 4;
  localparam int LAST = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  caesar_display_if dif ();

  caesar_display_core #(.DIV(DIV), .LAST_VAL(LAST)) dut (
    .Clk_50MHz (clk),
    .rst       (rst),
    .bus       (dif.slave)
  );

  logic [3:0] dec_in;
  logic [0:6] dec_out;
  caesar_seg7_dec u_dec (.bcd(dec_in), .seg(dec_out));

  // Segment patterns a..g, active-low, indexed by digit value.
  logic [0:6] seg_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  typedef struct {
    logic [4:0] sw;
    logic [0:6] h3;
    logic [0:6] h2;
  } sw_vec_t;

  typedef struct {
    logic [3:0] code;
    logic [0:6] seg;
  } dec_vec_t;

  sw_vec_t  sw_tab  [6];
  dec_vec_t dec_tab [16];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  // Reference letter counter: advances on every tick it sees; the DUT shows
  // the new value from the following cycle on.
  bit mon_en = 1'b0;
  bit have_prev;
  int model_cnt, ticks_seen, gap, highs;

  task automatic start_mon();
    model_cnt  = 0;
    ticks_seen = 0;
    have_prev  = 1'b0;
    gap        = 0;
    highs      = 0;
    mon_en     = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("cnt_hex0", dif.hex0, seg_ref[model_cnt % 10]);
      check("cnt_hex1", dif.hex1, seg_ref[model_cnt / 10]);
      if (dif.tick) begin
        if (have_prev) begin
          check("tick_period", gap, DIV);
          check("clk1hz_high_cycles", highs, DIV / 2);
        end
        have_prev = 1'b1;
        gap       = 0;
        highs     = 0;
        ticks_seen++;
        model_cnt = (model_cnt == LAST) ? 0 : model_cnt + 1;
      end
      gap++;
      highs += int'(dif.Clk_1Hz);
    end
  end

  // Wait until the model reaches v, then one more cycle so the DUT shows it.
  task automatic wait_value(input int v);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (model_cnt == v) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("reach_count_%0d", v), ok, 1'b1);
    @(negedge clk);
  endtask

  // Cycles from reset release to first tick: DIV plus up to two sync cycles.
  task automatic check_release_latency(input string name);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dif.tick) begin
        lat = i;
        break;
      end
    end
    check(name, (lat >= DIV && lat <= DIV + 2), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sw_tab[0] = '{5'd0,  7'b0000001, 7'b0000001};
    sw_tab[1] = '{5'd9,  7'b0000001, 7'b0000100};
    sw_tab[2] = '{5'd10, 7'b1001111, 7'b0000001};
    sw_tab[3] = '{5'd19, 7'b1001111, 7'b0000100};
    sw_tab[4] = '{5'd25, 7'b0010010, 7'b0100100};
    sw_tab[5] = '{5'd31, 7'b0000110, 7'b1001111};
    dec_tab[0] = '{4'd0, 7'b0000001};
    dec_tab[1] = '{4'd1, 7'b1001111};
    dec_tab[2] = '{4'd2, 7'b0010010};
    dec_tab[3] = '{4'd3, 7'b0000110};
    dec_tab[4] = '{4'd4, 7'b1001100};
    dec_tab[5] = '{4'd5, 7'b0100100};
    dec_tab[6] = '{4'd6, 7'b0100000};
    dec_tab[7] = '{4'd7, 7'b0001111};
    dec_tab[8] = '{4'd8, 7'b0000000};
    dec_tab[9] = '{4'd9, 7'b0000100};
    for (int i = 10; i < 16; i++) dec_tab[i] = '{4'(i), 7'b1111111};

    rst    = 1'b0;
    dif.sw = 5'd0;
    dec_in = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tick",    dif.tick,    1'b0);
    check("rst_clk1hz",  dif.Clk_1Hz, 1'b0);
    check("rst_hex0",    dif.hex0,    7'b0000001);
    check("rst_hex1",    dif.hex1,    7'b0000001);

    rst = 1'b1;
    start_mon();
    check_release_latency("first_tick_latency");

    // Counting, ones rollover and terminal wrap
    wait_value(9);
    check("cnt09_hex1", dif.hex1, 7'b0000001);
    check("cnt09_hex0", dif.hex0, 7'b0000100);
    wait_value(10);
    check("cnt10_hex1", dif.hex1, 7'b1001111);
    check("cnt10_hex0", dif.hex0, 7'b0000001);
    wait_value(25);
    check("cnt25_hex1", dif.hex1, 7'b0010010);
    check("cnt25_hex0", dif.hex0, 7'b0100100);
    wait_value(0);
    check("wrap_hex1", dif.hex1, 7'b0000001);
    check("wrap_hex0", dif.hex0, 7'b0000001);
    check("ticks_to_wrap", ticks_seen, LAST + 1);

    // Switch digits: fixed table, full sweep, then random values
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dif.sw = sw_tab[i].sw;
      #1;
      check($sformatf("swtab_hex3_%0d", sw_tab[i].sw), dif.hex3, sw_tab[i].h3);
      check($sformatf("swtab_hex2_%0d", sw_tab[i].sw), dif.hex2, sw_tab[i].h2);
    end
    for (int v = 0; v < 32 + 40; v++) begin
      int s;
      @(negedge clk);
      s = (v < 32) ? v : int'($urandom_range(31, 0));
      dif.sw = 5'(s);
      #1;
      check($sformatf("sw_hex3_%0d", s), dif.hex3, seg_ref[s / 10]);
      check($sformatf("sw_hex2_%0d", s), dif.hex2, seg_ref[s % 10]);
      check($sformatf("sw_hund_%0d", s), dif.bcd_hund, s / 100);
    end

    // Reset asserted mid-period while showing 17
    wait_value(17);
    check("pre_rst_hex1", dif.hex1, seg_ref[1]);
    check("pre_rst_hex0", dif.hex0, seg_ref[7]);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_hex0",   dif.hex0,    7'b0000001);
    check("midrst_hex1",   dif.hex1,    7'b0000001);
    check("midrst_tick",   dif.tick,    1'b0);
    check("midrst_clk1hz", dif.Clk_1Hz, 1'b0);
    repeat (3) @(negedge clk);
    check("held_rst_hex0", dif.hex0, 7'b0000001);
    rst = 1'b1;
    start_mon();
    check_release_latency("tick_latency_after_midrst");
    wait_value(2);
    check("resume_hex0", dif.hex0, 7'b0010010);
    mon_en = 1'b0;

    // Decoder direct, including blank codes 10..15
    for (int i = 0; i < 16; i++) begin
      dec_in = dec_tab[i].code;
      #1;
      check($sformatf("dec_%0d", dec_tab[i].code), dec_out, dec_tab[i].seg);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
